// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// master: the client that supplies operands and consumes results.
// slave:  the divider itself.
interface seq_divider_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             sign;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    logic             ovf;

    modport master (
        output in_valid, sign, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero, ovf
    );

    modport slave (
        input  in_valid, sign, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero, ovf
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle.
// Signed (truncating, remainder follows the dividend) or unsigned per operation.
// Optional macro DIV_ZERO_DETECT_EN: short-circuits a zero divisor straight to the
// fix-up stage and raises div_zero; without it div_zero is tied low.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    seq_divider_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] pr_reg;        // {partial remainder, quotient bits}
    logic [WIDTH-1:0]   dvsr_reg;      // divisor magnitude
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic               ovf_pend_reg;

    logic               in_ready_reg;
    logic               out_valid_reg;
    logic [WIDTH-1:0]   quotient_reg;
    logic [WIDTH-1:0]   remainder_reg;
    logic               ovf_reg;

`ifdef DIV_ZERO_DETECT_EN
    logic               dz_pend_reg;
    logic [WIDTH-1:0]   raw_dividend_reg;
    logic               div_zero_reg;
`endif

    logic               dividend_neg;
    logic               divisor_neg;
    logic [WIDTH-1:0]   dividend_mag;
    logic [WIDTH-1:0]   divisor_mag;
    logic               is_min_by_m1;
    logic [2*WIDTH:0]   pr_shift;
    logic [2*WIDTH:0]   trial;
    logic [WIDTH-1:0]   mag_q;
    logic [WIDTH-1:0]   mag_r;
    logic [WIDTH-1:0]   fix_q;
    logic [WIDTH-1:0]   fix_r;

    // Operand magnitudes, trial subtraction and sign fix-up values.
    always_comb begin
        dividend_neg = bus.sign & bus.dividend[WIDTH-1];
        divisor_neg  = bus.sign & bus.divisor[WIDTH-1];
        dividend_mag = dividend_neg ? (~bus.dividend + 1'b1) : bus.dividend;
        divisor_mag  = divisor_neg  ? (~bus.divisor  + 1'b1) : bus.divisor;
        is_min_by_m1 = bus.sign
                       && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                       && (bus.divisor  == {WIDTH{1'b1}});
        // The upper half of pr_reg is always below the divisor, so one extra
        // bit holds the shifted value and trial[2*WIDTH] is the borrow.
        pr_shift     = {pr_reg, 1'b0};
        trial        = pr_shift - {1'b0, dvsr_reg, {WIDTH{1'b0}}};
        mag_q        = pr_reg[WIDTH-1:0];
        mag_r        = pr_reg[2*WIDTH-1:WIDTH];
        fix_q        = neg_q_reg ? (~mag_q + 1'b1) : mag_q;
        fix_r        = neg_r_reg ? (~mag_r + 1'b1) : mag_r;
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            pr_reg           <= '0;
            dvsr_reg         <= '0;
            neg_q_reg        <= 1'b0;
            neg_r_reg        <= 1'b0;
            ovf_pend_reg     <= 1'b0;
            in_ready_reg     <= 1'b1;
            out_valid_reg    <= 1'b0;
            quotient_reg     <= '0;
            remainder_reg    <= '0;
            ovf_reg          <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            dz_pend_reg      <= 1'b0;
            raw_dividend_reg <= '0;
            div_zero_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        pr_reg       <= {{WIDTH{1'b0}}, dividend_mag};
                        dvsr_reg     <= divisor_mag;
                        neg_q_reg    <= dividend_neg ^ divisor_neg;
                        neg_r_reg    <= dividend_neg;
                        ovf_pend_reg <= is_min_by_m1;
                        in_ready_reg <= 1'b0;
                        cnt_reg      <= CNT_W'(WIDTH);
                        state_reg    <= RUN;
`ifdef DIV_ZERO_DETECT_EN
                        dz_pend_reg      <= (bus.divisor == '0);
                        raw_dividend_reg <= bus.dividend;
                        if (bus.divisor == '0) begin
                            // One settle cycle in FIX gives the zero-divide
                            // result its two-edge turnaround.
                            cnt_reg   <= CNT_W'(1);
                            state_reg <= FIX;
                        end
`endif
                    end
                end

                RUN: begin
                    if (trial[2*WIDTH]) begin
                        pr_reg <= pr_shift[2*WIDTH-1:0];
                    end else begin
                        pr_reg <= {trial[2*WIDTH-1:1], 1'b1};
                    end
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= FIX;
                    end
                end

                FIX: begin
`ifdef DIV_ZERO_DETECT_EN
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        if (dz_pend_reg) begin
                            quotient_reg  <= {WIDTH{1'b1}};
                            remainder_reg <= raw_dividend_reg;
                            ovf_reg       <= 1'b0;
                        end else begin
                            quotient_reg  <= fix_q;
                            remainder_reg <= fix_r;
                            ovf_reg       <= ovf_pend_reg;
                        end
                        div_zero_reg  <= dz_pend_reg;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
`else
                    quotient_reg  <= fix_q;
                    remainder_reg <= fix_r;
                    ovf_reg       <= ovf_pend_reg;
                    out_valid_reg <= 1'b1;
                    state_reg     <= DONE;
`endif
                end

                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.ovf       = ovf_reg;
`ifdef DIV_ZERO_DETECT_EN
    assign bus.div_zero  = div_zero_reg;
`else
    assign bus.div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider (WIDTH=8) against an
// arithmetic reference model.
module tb_seq_divider;
    localparam int W = 8;
`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with the rules for signed truncation,
    // overflow and zero divisors.
    task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic ov, output logic dz);
        int ia, ib, iq, ir;
        ov = 1'b0;
        dz = 1'b0;
        if (b == 0) begin
            q  = 8'hFF;
            r  = a;
            dz = DZ_EN;
        end else if (s) begin
            ia = $signed(a);
            ib = $signed(b);
            iq = ia / ib;
            ir = ia % ib;
            q  = iq[W-1:0];
            r  = ir[W-1:0];
            ov = (ia == -128) && (ib == -1);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // One full transaction: accept, wait for result, optionally stall the
    // consumer for 'hold' cycles while poking in_valid, then retire.
    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold);
        logic [W-1:0] eq, er;
        logic         eov, edz;
        int           lat;
        int           exp_lat;
        model(s, a, b, eq, er, eov, edz);
        exp_lat = (DZ_EN && b == 0) ? 2 : W + 1;

        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.sign      = s;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        bus.sign     = $urandom;

        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            check("busy_in_ready", bus.in_ready, 0);
        end while (!bus.out_valid && lat < 40);

        check("latency", lat, exp_lat);
        check("quotient", bus.quotient, eq);
        check("remainder", bus.remainder, er);
        check("ovf", bus.ovf, eov);
        check("div_zero", bus.div_zero, edz);
        $display("op s=%0d a=%02h b=%02h q=%02h r=%02h ovf=%0d dz=%0d lat=%0d hold=%0d",
                 s, a, b, bus.quotient, bus.remainder, bus.ovf, bus.div_zero, lat, hold);

        for (int i = 0; i < hold; i++) begin
            bus.in_valid = $urandom_range(0, 1);
            bus.dividend = $urandom;
            bus.divisor  = $urandom;
            @(posedge clk);
            #1;
            check("hold_out_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_quotient", bus.quotient, eq);
            check("hold_remainder", bus.remainder, er);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("retire_out_valid", bus.out_valid, 0);
        check("retire_in_ready", bus.in_ready, 1);
        check("kept_quotient", bus.quotient, eq);
    endtask

    initial begin
        logic         s;
        logic [W-1:0] a, b;
        n_checks = 0;
        n_fail   = 0;

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sign      = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_div_zero", bus.div_zero, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed cases from the plan.
        run_op(1'b0, 8'd100, 8'd7, 0);
        run_op(1'b1, 8'h9C, 8'd7, 0);
        run_op(1'b1, 8'd100, 8'hF9, 0);
        run_op(1'b1, 8'h80, 8'hFF, 0);
        run_op(1'b0, 8'h80, 8'hFF, 0);
        run_op(1'b0, 8'd100, 8'd7, 20);
        run_op(1'b0, 8'h35, 8'h00, 0);
        run_op(1'b1, 8'h7F, 8'h80, 2);

        // Reset in the middle of an iteration.
        run_op(1'b0, 8'd250, 8'd3, 0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.sign     = 1'b0;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_quotient", bus.quotient, 0);
        check("midrst_remainder", bus.remainder, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(1'b0, 8'd200, 8'd10, 0);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            s = $urandom_range(0, 1);
            a = $urandom;
            b = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            if (s && b == 0 && !DZ_EN) b = 8'h01;
            run_op(s, a, b, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
